// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial WIDTH-bit adder built around one 4-bit CLA
//
// cla4: 4-bit carry look-ahead adder slice
//   a, b  : 4-bit addends
//   ci    : carry in
//   s     : 4-bit sum
//   co    : carry out
//
// nibble_serial_adder: WIDTH-bit adder computing one nibble per clock
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : a/b/cin valid (accepted only while in_ready)
//   in_ready  : high in IDLE
//   a, b, cin : operands and carry into bit 0
//   out_valid : sum/cout/overflow valid (DONE)
//   out_ready : consumer accepts result
//   sum       : a + b + cin, low WIDTH bits
//   cout      : carry out of bit WIDTH-1
//   overflow  : two's-complement overflow
//   busy      : high in RUN or DONE

module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is formed directly from generate/propagate terms and ci,
   // so no carry waits on a lower one.
   assign c[0] = ci;
   assign c[1] = g[0]
               | (p[0] & ci);
   assign c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & ci);
   assign c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];

endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [IW-1:0]    idx;

   logic [IW+1:0]    base;
   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_s;
   logic             slice_co;
   logic             last;
   logic             accept;
   logic             step;

   // Bit offset of the current nibble.
   assign base    = {idx, 2'b00};
   assign slice_a = a_q[base +: 4];
   assign slice_b = b_q[base +: 4];
   assign last    = (idx == IW'(N - 1));

   cla4 u_cla (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // Only IDLE accepts operands, so a new operation can never
            // start on the edge that retires this result.
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         idx     <= '0;
         sum     <= '0;
      end else if (step) begin
         sum[base +: 4] <= slice_s;
         carry_q        <= slice_co;
         if (last) begin
            idx      <= '0;
            cout     <= slice_co;
            // The MSB's carry-in is recovered from its sum bit and addend
            // bits; signed overflow is that carry-in XOR the carry-out.
            overflow <= slice_co ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[3]);
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder

module tb_nibble_serial_adder;

   localparam int W = 16;
   localparam int N = W / 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: which phase the operation is in, how many nibble edges remain,
   // and the full-width arithmetic result computed at acceptance.
   typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;
   mphase_t       m_phase = M_IDLE;
   int            m_left  = 0;
   logic [W-1:0]  m_sum   = '0;
   logic          m_cout  = 1'b0;
   logic          m_ovf   = 1'b0;
   bit            m_live  = 1'b0;

   always @(posedge clk) begin
      logic [W:0] full;
      if (rst) begin
         m_phase = M_IDLE;
         m_live  = 1'b1;
      end else begin
         case (m_phase)
            M_IDLE: if (in_valid) begin
               full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
               m_sum   = full[W-1:0];
               m_cout  = full[W];
               m_ovf   = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
               m_left  = N;
               m_phase = M_RUN;
            end
            M_RUN: begin
               m_left--;
               if (m_left == 0) m_phase = M_DONE;
            end
            M_DONE: if (out_ready) m_phase = M_IDLE;
            default: m_phase = M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready",  32'(in_ready),  32'(m_phase == M_IDLE));
         chk("busy",      32'(busy),      32'(m_phase != M_IDLE));
         chk("out_valid", 32'(out_valid), 32'(m_phase == M_DONE));
         if (m_phase == M_DONE) begin
            chk("model_sum",  32'(sum),      32'(m_sum));
            chk("model_cout", 32'(cout),     32'(m_cout));
            chk("model_ovf",  32'(overflow), 32'(m_ovf));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
   endtask

   // Issues one operation from IDLE, checks latency and literal result,
   // then retires it with a one-cycle out_ready.
   task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
      int lat;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble();
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(N));
      chk({nm, "_sum"},  32'(sum),      32'(es));
      chk({nm, "_cout"}, 32'(cout),     32'(ec));
      chk({nm, "_ovf"},  32'(overflow), 32'(eo));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_ov_after"}, 32'(out_valid), 32'd0);
      chk({nm, "_ir_after"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1; out_ready = 1'b0;
      in_valid = 1'($urandom); scramble();
      tick();
      in_valid = 1'($urandom); out_ready = 1'($urandom); scramble();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(overflow),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();

      do_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      do_op("ripple",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      do_op("ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
      do_op("mixed",   16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Backpressure: result held in DONE while new operands are offered.
      a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'(N));
      a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_sum",       32'(sum),       32'h0406);
         chk("bp_cout",      32'(cout),      32'd0);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_ov", 32'(out_valid), 32'd0);
      chk("bp_release_ir", 32'(in_ready),  32'd1);
      do_op("after_bp", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

      // Reset while RUN: the operation is discarded without a result.
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_ov",   32'(out_valid), 32'd0);
      chk("mid_rst_sum",  32'(sum),       32'd0);
      chk("mid_rst_ir",   32'(in_ready),  32'd1);
      chk("mid_rst_busy", 32'(busy),      32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_no_result", 32'(out_valid), 32'd0);
      end
      do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
